// File: rtl/hbridge_drive_ctrl_pkg.sv
// Shared definitions for the H-bridge drive controller: direction codes,
// the illegal-direction check and the controller state encoding.
package hbridge_pkg;

  localparam logic [3:0] DIR_FWD   = 4'b1001;
  localparam logic [3:0] DIR_LEFT  = 4'b1010;
  localparam logic [3:0] DIR_RIGHT = 4'b0101;
  localparam logic [3:0] DIR_STOP  = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  // A pair driven 11 would short the bridge leg; such codes are rejected.
  function automatic logic dir_illegal(input logic [3:0] dir);
    return (dir[3:2] == 2'b11) || (dir[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/hbridge_drive_ctrl_if.sv
// Command handshake between navigation logic (master) and the drive controller (slave).
interface hbridge_drive_ctrl_if #(
  parameter int DUTY_W = 8
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_dir;
  logic [DUTY_W-1:0] cmd_duty;

  modport master (output cmd_valid, output cmd_dir, output cmd_duty, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, input cmd_duty, output cmd_ready);
endinterface

// File: rtl/hbridge_drive_ctrl_pwm_gen.sv
// PWM timebase: prescaler, free-running period counter, duty compare and
// a one-cycle strobe on the last tick of each period.
module pwm_gen #(
  parameter int DUTY_W   = 8,
  parameter int PRESCALE = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] duty,
  output logic              wrap,
  output logic              pwm_on
);
  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DUTY_W-1:0] CNT_MAX = '1;

  logic [PS_W-1:0]   presc_q, presc_d;
  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic              tick;

  always_comb begin
    tick      = (presc_q == PS_W'(PRESCALE - 1));
    presc_d   = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    wrap      = tick && (pwm_cnt_q == CNT_MAX);
    // Full-scale duty keeps the output on across the wrap as well.
    pwm_on    = (pwm_cnt_q < duty) || (duty == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

endmodule

// File: rtl/hbridge_drive_ctrl.sv
// H-bridge drive controller: command handshake, dead-time on reversal and EN PWM.
// Define HBRIDGE_SOFTSTART_EN to ramp duty upward one step per RAMP_STEP_CYC.
module hbridge_drive_ctrl
  import hbridge_pkg::*;
#(
  parameter int DUTY_W        = 8,
  parameter int PRESCALE      = 20,
  parameter int DEADTIME_CYC  = 100000,
  parameter int RAMP_STEP_CYC = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sw_ON,
  hbridge_drive_ctrl_if.slave  cmd,
  output logic [3:0]           IN,
  output logic [1:0]           EN,
  output logic                 busy,
  output logic                 fault
);
  localparam int DC_W = $clog2(DEADTIME_CYC + 1);

  if (PRESCALE < 1 || DEADTIME_CYC < 1 || RAMP_STEP_CYC < 1) begin : g_param_check
    $error("hbridge_drive_ctrl: cycle-count parameters must be at least 1");
  end

  state_t            state_q, state_d;
  logic [3:0]        in_q, in_d;
  logic [3:0]        dir_q, dir_d;
  logic [1:0]        en_q, en_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;
  logic              ready_q, ready_d;
  logic [DUTY_W-1:0] duty_cur_q, duty_cur_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DC_W-1:0]   dead_cnt_q, dead_cnt_d;
  logic [DUTY_W-1:0] duty_wrap;
  logic              accept, illegal, wrap, pwm_on;

  pwm_gen #(
    .DUTY_W   (DUTY_W),
    .PRESCALE (PRESCALE)
  ) u_pwm_gen (
    .clk    (clk),
    .rst    (rst),
    .duty   (duty_cur_q),
    .wrap   (wrap),
    .pwm_on (pwm_on)
  );

`ifdef HBRIDGE_SOFTSTART_EN
  localparam int RW = $clog2(RAMP_STEP_CYC + 1);
  logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic          ramp_ok, ramp_step;

  // Decreases land immediately at the wrap; increases wait for the ramp timer.
  always_comb begin
    ramp_ok   = (ramp_cnt_q == RW'(RAMP_STEP_CYC - 1));
    ramp_step = 1'b0;
    duty_wrap = duty_cur_q;
    if (target_q <= duty_cur_q) begin
      duty_wrap = target_q;
    end else if (ramp_ok) begin
      duty_wrap = duty_cur_q + 1'b1;
      ramp_step = 1'b1;
    end
  end

  always_comb begin
    ramp_cnt_d = ramp_cnt_q;
    if (state_q != RUN || state_d != RUN) begin
      ramp_cnt_d = '0;
    end else if (wrap && ramp_step) begin
      ramp_cnt_d = '0;
    end else if (!ramp_ok) begin
      ramp_cnt_d = ramp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ramp_cnt_q <= '0;
    else     ramp_cnt_q <= ramp_cnt_d;
  end
`else
  assign duty_wrap = target_q;
`endif

  always_comb begin
    state_d    = state_q;
    in_d       = in_q;
    dir_d      = dir_q;
    duty_cur_d = duty_cur_q;
    target_d   = target_q;
    dead_cnt_d = dead_cnt_q;
    accept     = cmd.cmd_valid && ready_q;
    illegal    = dir_illegal(cmd.cmd_dir);
    fault_d    = accept && illegal;

    // dir_q remembers the last legal direction, which is also the one pending in DEAD.
    if (accept && !illegal) begin
      target_d = cmd.cmd_duty;
      dir_d    = cmd.cmd_dir;
    end

    if (!sw_ON) begin
      state_d    = IDLE;
      in_d       = DIR_STOP;
      duty_cur_d = '0;
      dead_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dir_d != DIR_STOP) begin
            state_d    = RUN;
            in_d       = dir_d;
            duty_cur_d = '0;
          end
        end
        RUN: begin
          if (accept && !illegal && cmd.cmd_dir != in_q) begin
            state_d    = (cmd.cmd_dir == DIR_STOP) ? IDLE : DEAD;
            in_d       = DIR_STOP;
            duty_cur_d = '0;
            dead_cnt_d = '0;
          end else if (wrap) begin
            duty_cur_d = duty_wrap;
          end
        end
        DEAD: begin
          if (dead_cnt_q == DC_W'(DEADTIME_CYC - 1)) begin
            state_d    = RUN;
            in_d       = dir_q;
            dead_cnt_d = '0;
          end else begin
            dead_cnt_d = dead_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d    = IDLE;
          in_d       = DIR_STOP;
          duty_cur_d = '0;
        end
      endcase
    end

    // duty_cur_q is 0 whenever RUN is entered, so EN cannot carry a stale pulse.
    en_d[1] = (state_d == RUN) && (in_d[3:2] != 2'b00) && pwm_on;
    en_d[0] = (state_d == RUN) && (in_d[1:0] != 2'b00) && pwm_on;
    busy_d  = (state_d == DEAD);
    ready_d = (state_d != DEAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      in_q       <= DIR_STOP;
      dir_q      <= DIR_STOP;
      en_q       <= 2'b00;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      ready_q    <= 1'b0;
      duty_cur_q <= '0;
      target_q   <= '0;
      dead_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      in_q       <= in_d;
      dir_q      <= dir_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
      ready_q    <= ready_d;
      duty_cur_q <= duty_cur_d;
      target_q   <= target_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

  assign IN            = in_q;
  assign EN            = en_q;
  assign busy          = busy_q;
  assign fault         = fault_q;
  assign cmd.cmd_ready = ready_q;

endmodule

// File: tb/tb_hbridge_drive_ctrl.sv
// Directed self-checking bench for hbridge_drive_ctrl (DUTY_W=4, PRESCALE=1, DEADTIME_CYC=8).
module tb_hbridge_drive_ctrl;
  import hbridge_pkg::*;

  localparam int DUTY_W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_ON;
  logic [3:0] IN;
  logic [1:0] EN;
  logic       busy;
  logic       fault;
  int         checks = 0;
  int         failures = 0;

  hbridge_drive_ctrl_if #(.DUTY_W(DUTY_W)) cmd_if ();

  hbridge_drive_ctrl #(
    .DUTY_W        (DUTY_W),
    .PRESCALE      (1),
    .DEADTIME_CYC  (8),
    .RAMP_STEP_CYC (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sw_ON (sw_ON),
    .cmd   (cmd_if),
    .IN    (IN),
    .EN    (EN),
    .busy  (busy),
    .fault (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents a command at a falling edge and holds it until accepted.
  task automatic send_cmd(input logic [3:0] dir, input logic [DUTY_W-1:0] duty);
    int n;
    n = 0;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = dir;
    cmd_if.cmd_duty  = duty;
    while (cmd_if.cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      $display("FAIL send_cmd_timeout: dir=%b ready=%b required ready=1", dir, cmd_if.cmd_ready);
      failures++;
    end
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    $display("cmd dir=%b duty=%0d -> IN=%b EN=%b busy=%b fault=%b", dir, duty, IN, EN, busy, fault);
  endtask

  // Length of the next EN[1] high run; -1 if none appears within the bound.
  task automatic measure_run(output int len);
    int n;
    n   = 0;
    len = 0;
    while (EN[1] !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      len = -1;
    end else begin
      while (EN[1] === 1'b1 && len < 64) begin
        len++;
        @(negedge clk);
      end
    end
  endtask

  task automatic count_en(output int ones, output int zeros, output int other);
    ones = 0; zeros = 0; other = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (EN === 2'b11) ones++;
      else if (EN === 2'b00) zeros++;
      else other++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw_ON = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dir = 4'b0000;
    cmd_if.cmd_duty = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({IN, EN, cmd_if.cmd_ready, busy, fault} !== 9'b0) begin
      $display("FAIL reset_outputs: IN=%b EN=%b ready=%b busy=%b fault=%b required all 0",
               IN, EN, cmd_if.cmd_ready, busy, fault);
      failures++;
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1 || IN !== 4'b0000) begin
      $display("FAIL reset_release: ready=%b IN=%b required ready=1 IN=0000", cmd_if.cmd_ready, IN);
      failures++;
    end
    $display("reset done: ready=%b", cmd_if.cmd_ready);
  endtask

  task automatic test_basic_run();
    int ones, zeros, other;
    sw_ON = 1'b1;
    send_cmd(DIR_FWD, 4'd8);
    checks++;
    if (IN !== DIR_FWD || busy !== 1'b0) begin
      $display("FAIL basic_in: IN=%b busy=%b required IN=1001 busy=0", IN, busy);
      failures++;
    end
    repeat (300) @(negedge clk);
    count_en(ones, zeros, other);
    checks++;
    if (ones !== 16 || zeros !== 16 || other !== 0) begin
      $display("FAIL basic_pwm: high=%0d low=%0d other=%0d required 16/16/0", ones, zeros, other);
      failures++;
    end
  endtask

  task automatic test_full_and_zero();
    int ones, zeros, other;
    send_cmd(DIR_FWD, 4'd15);
    checks++;
    if (IN !== DIR_FWD || busy !== 1'b0) begin
      $display("FAIL same_dir_no_dead: IN=%b busy=%b required IN=1001 busy=0", IN, busy);
      failures++;
    end
    repeat (300) @(negedge clk);
    count_en(ones, zeros, other);
    checks++;
    if (ones !== 32) begin
      $display("FAIL full_duty: high=%0d of 32 required 32", ones);
      failures++;
    end
    send_cmd(DIR_FWD, 4'd0);
    repeat (40) @(negedge clk);
    count_en(ones, zeros, other);
    checks++;
    if (zeros !== 32) begin
      $display("FAIL zero_duty: low=%0d of 32 required 32", zeros);
      failures++;
    end
  endtask

  task automatic test_fault();
    send_cmd(4'b1100, 4'd5);
    checks++;
    if (fault !== 1'b1 || IN !== DIR_FWD || EN !== 2'b00 || busy !== 1'b0) begin
      $display("FAIL fault_pulse: fault=%b IN=%b EN=%b busy=%b required 1/1001/00/0", fault, IN, EN, busy);
      failures++;
    end
    @(negedge clk);
    checks++;
    if (fault !== 1'b0 || IN !== DIR_FWD) begin
      $display("FAIL fault_clear: fault=%b IN=%b required fault=0 IN=1001", fault, IN);
      failures++;
    end
  endtask

  task automatic test_deadtime();
    int  cnt;
    bit  bad;
    send_cmd(DIR_FWD, 4'd8);
    repeat (300) @(negedge clk);
    send_cmd(DIR_RIGHT, 4'd8);
    cnt = 0;
    bad = 1'b0;
    while (busy === 1'b1 && cnt < 50) begin
      if (IN !== 4'b0000 || EN !== 2'b00 || cmd_if.cmd_ready !== 1'b0) bad = 1'b1;
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt !== 8) begin
      $display("FAIL dead_length: busy cycles=%0d required 8", cnt);
      failures++;
    end
    checks++;
    if (bad) begin
      $display("FAIL dead_outputs: IN/EN/ready not held at 0000/00/0 during DEAD (bad=%b required 0)", bad);
      failures++;
    end
    checks++;
    if (IN !== DIR_RIGHT || EN !== 2'b00 || cmd_if.cmd_ready !== 1'b1) begin
      $display("FAIL dead_exit: IN=%b EN=%b ready=%b required 0101/00/1", IN, EN, cmd_if.cmd_ready);
      failures++;
    end
    $display("deadtime: busy for %0d cycles, IN=%b", cnt, IN);
  endtask

  task automatic test_stop_restart();
    send_cmd(DIR_STOP, 4'd8);
    checks++;
    if (IN !== DIR_STOP || EN !== 2'b00 || busy !== 1'b0) begin
      $display("FAIL stop: IN=%b EN=%b busy=%b required 0000/00/0", IN, EN, busy);
      failures++;
    end
    send_cmd(DIR_LEFT, 4'd8);
    checks++;
    if (IN !== DIR_LEFT || busy !== 1'b0) begin
      $display("FAIL restart_no_dead: IN=%b busy=%b required IN=1010 busy=0", IN, busy);
      failures++;
    end
  endtask

  task automatic test_softstart();
    int exp_runs[4];
    int len;
`ifdef HBRIDGE_SOFTSTART_EN
    exp_runs = '{1, 2, 3, 4};
`else
    exp_runs = '{4, 4, 4, 4};
`endif
    send_cmd(DIR_STOP, 4'd0);
    send_cmd(DIR_FWD, 4'd4);
    for (int i = 0; i < 4; i++) begin
      measure_run(len);
      checks++;
      if (len !== exp_runs[i]) begin
        $display("FAIL ramp_run%0d: high-time=%0d required %0d", i, len, exp_runs[i]);
        failures++;
      end
      $display("ramp period %0d: high-time=%0d", i, len);
    end
    send_cmd(DIR_FWD, 4'd1);
    measure_run(len);
    checks++;
    if (len !== 1) begin
      $display("FAIL ramp_drop: high-time=%0d required 1", len);
      failures++;
    end
  endtask

  task automatic test_sw_off();
    int n;
    send_cmd(DIR_FWD, 4'd8);
    repeat (300) @(negedge clk);
    n = 0;
    while (EN !== 2'b11 && n < 64) begin
      @(negedge clk);
      n++;
    end
    sw_ON = 1'b0;
    @(negedge clk);
    checks++;
    if (n >= 64 || IN !== 4'b0000 || EN !== 2'b00 || busy !== 1'b0) begin
      $display("FAIL sw_off: wait=%0d IN=%b EN=%b busy=%b required IN=0000 EN=00 busy=0", n, IN, EN, busy);
      failures++;
    end
    send_cmd(DIR_RIGHT, 4'd8);
    checks++;
    if (IN !== 4'b0000 || EN !== 2'b00) begin
      $display("FAIL sw_off_hold: IN=%b EN=%b required 0000/00", IN, EN);
      failures++;
    end
    sw_ON = 1'b1;
    @(negedge clk);
    checks++;
    if (IN !== DIR_RIGHT || busy !== 1'b0) begin
      $display("FAIL sw_on_resume: IN=%b busy=%b required IN=0101 busy=0", IN, busy);
      failures++;
    end
  endtask

  task automatic test_rst_in_dead();
    send_cmd(DIR_FWD, 4'd8);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL dead_entry: busy=%b required 1", busy);
      failures++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({IN, EN, cmd_if.cmd_ready, busy, fault} !== 9'b0) begin
      $display("FAIL rst_in_dead: IN=%b EN=%b ready=%b busy=%b fault=%b required all 0",
               IN, EN, cmd_if.cmd_ready, busy, fault);
      failures++;
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0 || IN !== 4'b0000) begin
      $display("FAIL rst_release: ready=%b busy=%b IN=%b required 1/0/0000", cmd_if.cmd_ready, busy, IN);
      failures++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_full_and_zero();
    test_fault();
    test_deadtime();
    test_stop_restart();
    test_softstart();
    test_sw_off();
    test_rst_in_dead();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
